// File: rtl/cache_axi_bridge.sv
// Bridges L1 cache refill/write-back requests onto an AXI4 master port.
// One read and one write may be in flight at a time, each with its own FSM.
module cache_axi_bridge #(
    parameter logic [3:0]  AXI_ID     = 4'd0,
    parameter int unsigned LINE_BEATS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_req,
    input  logic [2:0]               rd_type,
    input  logic [31:0]              rd_addr,
    output logic                     rd_rdy,
    output logic                     ret_valid,
    output logic                     ret_last,
    output logic [31:0]              ret_data,
    input  logic                     wr_req,
    input  logic [2:0]               wr_type,
    input  logic [31:0]              wr_addr,
    input  logic [3:0]               wr_wstrb,
    input  logic [32*LINE_BEATS-1:0] wr_data,
    output logic                     wr_rdy,
    output logic [3:0]               arid,
    output logic [31:0]              araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [3:0]               rid,
    input  logic [31:0]              rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready,
    output logic [3:0]               awid,
    output logic [31:0]              awaddr,
    output logic [7:0]               awlen,
    output logic [2:0]               awsize,
    output logic [1:0]               awburst,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [31:0]              wdata,
    output logic [3:0]               wstrb,
    output logic                     wlast,
    output logic                     wvalid,
    input  logic                     wready,
    input  logic [3:0]               bid,
    input  logic [1:0]               bresp,
    input  logic                     bvalid,
    output logic                     bready
);

    localparam int unsigned BEAT_W     = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam logic [2:0]  TYPE_LINE  = 3'b100;
    localparam logic [1:0]  BURST_INCR = 2'b01;
    localparam logic [7:0]  LINE_LEN   = 8'(LINE_BEATS - 1);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} wstate_t;

    rstate_t rstate, rstate_nxt;
    wstate_t wstate, wstate_nxt;

    logic                         raw_hazard;
    logic                         rd_accept;
    logic                         wr_accept;
    logic [31:0]                  wbuf_addr;
    logic                         wbuf_line;
    logic [2:0]                   wbuf_size;
    logic [3:0]                   wbuf_strb;
    logic [LINE_BEATS-1:0][31:0]  wbuf_data;
    logic [BEAT_W-1:0]            beat_cnt;
    logic                         aw_done;
    logic                         w_done;

    // Response IDs and codes are not used by the caches.
    logic unused_ok;
    assign unused_ok = ^{rid, rresp, bid, bresp};

    // Read of a line that is still being written back waits for the B response.
    assign raw_hazard = (wstate != W_IDLE) && (rd_addr[31:4] == wbuf_addr[31:4]);
    assign rd_rdy     = rst && (rstate == R_IDLE) && !raw_hazard;
    assign rd_accept  = rd_req && rd_rdy;
    assign wr_rdy     = rst && (wstate == W_IDLE);
    assign wr_accept  = wr_req && wr_rdy;

    assign ret_valid = rvalid && rready;
    assign ret_last  = rlast;
    assign ret_data  = rdata;

    assign arid    = AXI_ID;
    assign arburst = BURST_INCR;
    assign awid    = AXI_ID;
    assign awburst = BURST_INCR;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rstate <= R_IDLE;
            wstate <= W_IDLE;
        end else begin
            rstate <= rstate_nxt;
            wstate <= wstate_nxt;
        end
    end

    always_comb begin
        rstate_nxt = rstate;
        arvalid    = 1'b0;
        rready     = 1'b0;
        case (rstate)
            R_IDLE: if (rd_accept) rstate_nxt = R_AR;
            R_AR: begin
                arvalid = 1'b1;
                if (arready) rstate_nxt = R_DATA;
            end
            R_DATA: begin
                rready = 1'b1;
                if (rvalid && rlast) rstate_nxt = R_IDLE;
            end
            default: rstate_nxt = R_IDLE;
        endcase
    end

    // W_SEND leaves once both AW and the last W beat have been accepted, in any order.
    always_comb begin
        wstate_nxt = wstate;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        case (wstate)
            W_IDLE: if (wr_accept) wstate_nxt = W_SEND;
            W_SEND: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || awready) && (w_done || (wready && wlast)))
                    wstate_nxt = W_RESP;
            end
            W_RESP: begin
                bready = 1'b1;
                if (bvalid) wstate_nxt = W_IDLE;
            end
            default: wstate_nxt = W_IDLE;
        endcase
    end

    // AR payload is captured at acceptance and held until the next request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            araddr <= 32'd0;
            arlen  <= 8'd0;
            arsize <= 3'd0;
        end else if (rd_accept) begin
            if (rd_type == TYPE_LINE) begin
                araddr <= {rd_addr[31:4], 4'b0000};
                arlen  <= LINE_LEN;
                arsize <= 3'd2;
            end else begin
                araddr <= rd_addr;
                arlen  <= 8'd0;
                arsize <= {1'b0, rd_type[1:0]};
            end
        end
    end

    // Write buffer and per-channel progress tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbuf_addr <= 32'd0;
            wbuf_line <= 1'b0;
            wbuf_size <= 3'd0;
            wbuf_strb <= 4'd0;
            wbuf_data <= '0;
            beat_cnt  <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else if (wr_accept) begin
            wbuf_addr <= wr_addr;
            wbuf_line <= (wr_type == TYPE_LINE);
            wbuf_size <= (wr_type == TYPE_LINE) ? 3'd2 : {1'b0, wr_type[1:0]};
            wbuf_strb <= wr_wstrb;
            wbuf_data <= wr_data;
            beat_cnt  <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            if (awvalid && awready) aw_done <= 1'b1;
            if (wvalid && wready) begin
                beat_cnt <= BEAT_W'(beat_cnt + 1'b1);
                if (wlast) w_done <= 1'b1;
            end
        end
    end

    assign awaddr = wbuf_line ? {wbuf_addr[31:4], 4'b0000} : wbuf_addr;
    assign awlen  = wbuf_line ? LINE_LEN : 8'd0;
    assign awsize = wbuf_size;
    assign wdata  = wbuf_line ? wbuf_data[beat_cnt] : wbuf_data[0];
    assign wstrb  = wbuf_line ? 4'hF : wbuf_strb;
    assign wlast  = wbuf_line ? (beat_cnt == BEAT_W'(LINE_BEATS - 1)) : 1'b1;

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Scenario bench for cache_axi_bridge: scripted AXI slave, queued expectations
// for R returns and W beats checked by a monitor as the handshakes happen.
module tb_cache_axi_bridge;

    logic         clk;
    logic         rst;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic [3:0]   awid;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [3:0]   bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;

    int n_checks = 0;
    int n_errors = 0;

    logic [32:0] exp_ret[$];
    logic [36:0] exp_w[$];
    logic [32:0] e_ret;
    logic [36:0] e_w;

    cache_axi_bridge dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; this monitor looks just before the rising edge.
    always begin
        @(negedge clk);
        #2;
        if (ret_valid) begin
            n_checks++;
            if (exp_ret.size() == 0) begin
                n_errors++;
                $display("FAIL ret_unexpected: got data=%h last=%b, no return expected", ret_data, ret_last);
            end else begin
                e_ret = exp_ret.pop_front();
                if ({ret_data, ret_last} !== e_ret) begin
                    n_errors++;
                    $display("FAIL ret_beat: got data=%h last=%b want data=%h last=%b",
                             ret_data, ret_last, e_ret[32:1], e_ret[0]);
                end
            end
        end
        if (wvalid && wready) begin
            n_checks++;
            if (exp_w.size() == 0) begin
                n_errors++;
                $display("FAIL w_unexpected: got wdata=%h wstrb=%h wlast=%b", wdata, wstrb, wlast);
            end else begin
                e_w = exp_w.pop_front();
                if ({wdata, wstrb, wlast} !== e_w) begin
                    n_errors++;
                    $display("FAIL w_beat: got wdata=%h wstrb=%h wlast=%b want wdata=%h wstrb=%h wlast=%b",
                             wdata, wstrb, wlast, e_w[36:5], e_w[4:1], e_w[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_checks++;
        if ({arvalid, rready, awvalid, wvalid, bready, rd_rdy, wr_rdy, ret_valid} !== 8'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b want 00000000",
                     {arvalid, rready, awvalid, wvalid, bready, rd_rdy, wr_rdy, ret_valid});
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({rd_rdy, wr_rdy} !== 2'b11) begin
            n_errors++;
            $display("FAIL reset_release_rdy: got rd_rdy=%b wr_rdy=%b want 1 1", rd_rdy, wr_rdy);
        end
    endtask

    task automatic test_line_read(input string tag);
        @(negedge clk);
        rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h1C00_0024;
        #1;
        n_checks++;
        if (rd_rdy !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_rd_rdy: got %b want 1", tag, rd_rdy);
        end
        @(negedge clk);
        rd_req = 1'b0;
        #1;
        n_checks++;
        if ({arvalid, araddr, arlen, arsize, arburst, arid} !== {1'b1, 32'h1C00_0020, 8'd3, 3'd2, 2'b01, 4'd0}) begin
            n_errors++;
            $display("FAIL %s_ar: got v=%b addr=%h len=%0d size=%0d burst=%0d id=%0d want 1 1c000020 3 2 1 0",
                     tag, arvalid, araddr, arlen, arsize, arburst, arid);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if ({arvalid, araddr, arlen, rready} !== {1'b1, 32'h1C00_0020, 8'd3, 1'b0}) begin
                n_errors++;
                $display("FAIL %s_ar_hold: got v=%b addr=%h len=%0d rready=%b want 1 1c000020 3 0",
                         tag, arvalid, araddr, arlen, rready);
            end
        end
        @(negedge clk);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        #1;
        n_checks++;
        if ({arvalid, rready} !== 2'b01) begin
            n_errors++;
            $display("FAIL %s_r_phase: got arvalid=%b rready=%b want 0 1", tag, arvalid, rready);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rvalid = 1'b1; rdata = 32'hA0 + 32'(i); rlast = (i == 3);
            exp_ret.push_back({rdata, rlast});
        end
        @(negedge clk);
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        n_checks++;
        if ({rd_rdy, rready} !== 2'b10 || exp_ret.size() != 0) begin
            n_errors++;
            $display("FAIL %s_done: got rd_rdy=%b rready=%b pending=%0d want 1 0 0",
                     tag, rd_rdy, rready, exp_ret.size());
        end
    endtask

    task automatic test_word_read();
        @(negedge clk);
        rd_req = 1'b1; rd_type = 3'b010; rd_addr = 32'h8000_0004;
        @(negedge clk);
        rd_req = 1'b0; arready = 1'b1;
        #1;
        n_checks++;
        if ({arvalid, araddr, arlen, arsize} !== {1'b1, 32'h8000_0004, 8'd0, 3'd2}) begin
            n_errors++;
            $display("FAIL word_ar: got v=%b addr=%h len=%0d size=%0d want 1 80000004 0 2",
                     arvalid, araddr, arlen, arsize);
        end
        @(negedge clk);
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h1234_5678; rlast = 1'b1;
        exp_ret.push_back({rdata, rlast});
        @(negedge clk);
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        n_checks++;
        if (rd_rdy !== 1'b1 || exp_ret.size() != 0) begin
            n_errors++;
            $display("FAIL word_done: got rd_rdy=%b pending=%0d want 1 0", rd_rdy, exp_ret.size());
        end
    endtask

    task automatic test_line_write();
        logic [127:0] d;
        d = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        @(negedge clk);
        wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h3000_0014; wr_wstrb = 4'h0; wr_data = d;
        wready = 1'b1; awready = 1'b0;
        for (int i = 0; i < 4; i++) exp_w.push_back({d[32*i +: 32], 4'hF, (i == 3)});
        #1;
        n_checks++;
        if (wr_rdy !== 1'b1) begin
            n_errors++;
            $display("FAIL lw_wr_rdy: got %b want 1", wr_rdy);
        end
        @(negedge clk);
        wr_req = 1'b0;
        #1;
        n_checks++;
        if ({awvalid, awaddr, awlen, awsize, awburst, wvalid} !== {1'b1, 32'h3000_0010, 8'd3, 3'd2, 2'b01, 1'b1}) begin
            n_errors++;
            $display("FAIL lw_aw: got v=%b addr=%h len=%0d size=%0d burst=%0d wvalid=%b want 1 30000010 3 2 1 1",
                     awvalid, awaddr, awlen, awsize, awburst, wvalid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if ({awvalid, awaddr, bready, wr_rdy} !== {1'b1, 32'h3000_0010, 1'b0, 1'b0}) begin
                n_errors++;
                $display("FAIL lw_aw_wait: got awvalid=%b addr=%h bready=%b wr_rdy=%b want 1 30000010 0 0",
                         awvalid, awaddr, bready, wr_rdy);
            end
        end
        @(negedge clk);
        awready = 1'b1;
        #1;
        n_checks++;
        if (wvalid !== 1'b0 || exp_w.size() != 0 || bready !== 1'b0) begin
            n_errors++;
            $display("FAIL lw_w_first: got wvalid=%b pending=%0d bready=%b want 0 0 0", wvalid, exp_w.size(), bready);
        end
        @(negedge clk);
        awready = 1'b0;
        #1;
        n_checks++;
        if ({bready, awvalid, wr_rdy} !== 3'b100) begin
            n_errors++;
            $display("FAIL lw_resp: got bready=%b awvalid=%b wr_rdy=%b want 1 0 0", bready, awvalid, wr_rdy);
        end
        bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0; wready = 1'b0;
        #1;
        n_checks++;
        if ({wr_rdy, bready} !== 2'b10) begin
            n_errors++;
            $display("FAIL lw_done: got wr_rdy=%b bready=%b want 1 0", wr_rdy, bready);
        end
    endtask

    task automatic test_single_write();
        @(negedge clk);
        wr_req = 1'b1; wr_type = 3'b000; wr_addr = 32'h0000_1002; wr_wstrb = 4'b0100;
        wr_data = {96'h0, 32'h00AB_0000};
        awready = 1'b1; wready = 1'b1;
        exp_w.push_back({32'h00AB_0000, 4'b0100, 1'b1});
        @(negedge clk);
        wr_req = 1'b0;
        #1;
        n_checks++;
        if ({awvalid, awaddr, awlen, awsize} !== {1'b1, 32'h0000_1002, 8'd0, 3'd0}) begin
            n_errors++;
            $display("FAIL sw_aw: got v=%b addr=%h len=%0d size=%0d want 1 00001002 0 0",
                     awvalid, awaddr, awlen, awsize);
        end
        @(negedge clk);
        awready = 1'b0; wready = 1'b0;
        #1;
        n_checks++;
        if ({bready, awvalid, wvalid} !== 3'b100 || exp_w.size() != 0) begin
            n_errors++;
            $display("FAIL sw_resp: got bready=%b awvalid=%b wvalid=%b pending=%0d want 1 0 0 0",
                     bready, awvalid, wvalid, exp_w.size());
        end
        bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0;
        #1;
        n_checks++;
        if (wr_rdy !== 1'b1) begin
            n_errors++;
            $display("FAIL sw_done: got wr_rdy=%b want 1", wr_rdy);
        end
    endtask

    task automatic test_raw_hazard();
        logic [127:0] d;
        bit seen;
        d = 128'hDDDD_0003_DDDD_0002_DDDD_0001_DDDD_0000;
        @(negedge clk);
        wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h2000_0010; wr_data = d;
        awready = 1'b0; wready = 1'b0;
        for (int i = 0; i < 4; i++) exp_w.push_back({d[32*i +: 32], 4'hF, (i == 3)});
        @(negedge clk);
        wr_req = 1'b0;
        rd_req = 1'b1; rd_type = 3'b010; rd_addr = 32'h2000_0018;
        #1;
        n_checks++;
        if (rd_rdy !== 1'b0) begin
            n_errors++;
            $display("FAIL raw_block: got rd_rdy=%b want 0", rd_rdy);
        end
        @(negedge clk);
        rd_addr = 32'h2000_0020;
        #1;
        n_checks++;
        if (rd_rdy !== 1'b1) begin
            n_errors++;
            $display("FAIL raw_other_line: got rd_rdy=%b want 1", rd_rdy);
        end
        @(negedge clk);
        rd_req = 1'b0; arready = 1'b1;
        #1;
        n_checks++;
        if ({arvalid, araddr} !== {1'b1, 32'h2000_0020}) begin
            n_errors++;
            $display("FAIL raw_other_ar: got v=%b addr=%h want 1 20000020", arvalid, araddr);
        end
        @(negedge clk);
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h5555_0020; rlast = 1'b1;
        exp_ret.push_back({rdata, rlast});
        @(negedge clk);
        rvalid = 1'b0; rlast = 1'b0;
        rd_req = 1'b1; rd_addr = 32'h2000_0018;
        awready = 1'b1; wready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            n_checks++;
            if (rd_rdy !== 1'b0) begin
                n_errors++;
                $display("FAIL raw_hold: got rd_rdy=%b want 0 (cycle %0d)", rd_rdy, i);
            end
            if (bready === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL raw_bready_timeout: got bready=%b want 1 within 20 cycles", bready);
        end
        bvalid = 1'b1; awready = 1'b0; wready = 1'b0;
        @(negedge clk);
        bvalid = 1'b0;
        #1;
        n_checks++;
        if (rd_rdy !== 1'b1 || exp_w.size() != 0) begin
            n_errors++;
            $display("FAIL raw_release: got rd_rdy=%b pending_w=%0d want 1 0", rd_rdy, exp_w.size());
        end
        @(negedge clk);
        rd_req = 1'b0; arready = 1'b1;
        #1;
        n_checks++;
        if ({arvalid, araddr} !== {1'b1, 32'h2000_0018}) begin
            n_errors++;
            $display("FAIL raw_ar: got v=%b addr=%h want 1 20000018", arvalid, araddr);
        end
        @(negedge clk);
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h5555_0018; rlast = 1'b1;
        exp_ret.push_back({rdata, rlast});
        @(negedge clk);
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        n_checks++;
        if (rd_rdy !== 1'b1 || exp_ret.size() != 0) begin
            n_errors++;
            $display("FAIL raw_done: got rd_rdy=%b pending=%0d want 1 0", rd_rdy, exp_ret.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h1C00_0024;
        @(negedge clk);
        rd_req = 1'b0; arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hA0; rlast = 1'b0;
        exp_ret.push_back({rdata, rlast});
        @(negedge clk);
        rdata = 32'hA1;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({arvalid, rready, ret_valid, rd_rdy, wr_rdy} !== 5'b0 || exp_ret.size() != 0) begin
            n_errors++;
            $display("FAIL rst_mid: got ar=%b rr=%b ret=%b rd_rdy=%b wr_rdy=%b pending=%0d want 0 0 0 0 0 0",
                     arvalid, rready, ret_valid, rd_rdy, wr_rdy, exp_ret.size());
        end
        @(negedge clk);
        rvalid = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({rd_rdy, wr_rdy, rready} !== 3'b110) begin
            n_errors++;
            $display("FAIL rst_release: got rd_rdy=%b wr_rdy=%b rready=%b want 1 1 0", rd_rdy, wr_rdy, rready);
        end
        test_line_read("post_rst");
    endtask

    initial begin
        rst = 1'b0;
        rd_req = 1'b0; rd_type = 3'b000; rd_addr = 32'h0;
        wr_req = 1'b0; wr_type = 3'b000; wr_addr = 32'h0; wr_wstrb = 4'h0; wr_data = 128'h0;
        arready = 1'b0; rid = 4'h0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = 4'h0; bresp = 2'b00; bvalid = 1'b0;
        test_reset();
        test_line_read("line_read");
        test_word_read();
        test_line_write();
        test_single_write();
        test_raw_hazard();
        test_reset_mid_burst();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cache_axi_bridge.md
Name: cache_axi_bridge

Overview:
Memory-side responder for the dcache/icache refill interface. It accepts cache read requests (rd_req/rd_type/rd_addr) and cache write-back requests (wr_req/wr_type/wr_addr/wr_wstrb/wr_data), issues them as AXI4 master transactions, and returns read beats to the cache on ret_valid/ret_last/ret_data. It sits between the L1 caches and the SoC AXI interconnect. It supports one outstanding read and one outstanding write, with the two running independently.

Parameters:
AXI_ID, 4'd0, constant ARID/AWID value
LINE_BEATS, 4, 32-bit beats per cache line (16 B line)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
rd_req  in  1  cache read request
rd_type  in  3  000 byte, 001 half, 010 word, 100 cache line
rd_addr  in  32  read start address
rd_rdy  out  1  read request accepted this cycle when rd_req=1
ret_valid  out  1  read beat valid
ret_last  out  1  last beat of the read
ret_data  out  32  read beat data
wr_req  in  1  cache write request
wr_type  in  3  encoding as rd_type
wr_addr  in  32  write start address
wr_wstrb  in  4  byte mask; used for non-line writes only
wr_data  in  128  line data, or a single word in [31:0]
wr_rdy  out  1  write request accepted this cycle when wr_req=1
arid/araddr/arlen/arsize/arburst/arvalid  out  4/32/8/3/2/1  AXI AR
arready  in  1
rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  AXI R
rready  out  1
awid/awaddr/awlen/awsize/awburst/awvalid  out  4/32/8/3/2/1  AXI AW
awready  in  1
wdata/wstrb/wlast/wvalid  out  32/4/1/1  AXI W
wready  in  1
bid/bresp/bvalid  in  4/2/1  AXI B
bready  out  1

Behaviour:
- Reset (rst=0, asynchronous): read FSM and write FSM go to IDLE. arvalid, rready, awvalid, wvalid and bready are 0. rd_rdy, wr_rdy and ret_valid are 0 while rst=0. Write buffer and beat counter clear to 0.
- Read FSM, states R_IDLE -> R_AR -> R_DATA -> R_IDLE:
  - rd_rdy = rst & (rstate==R_IDLE) & !raw_hazard.
  - Acceptance (rd_req & rd_rdy) latches the request. arvalid rises on the next cycle and holds until arready.
  - rd_type=100: araddr={rd_addr[31:4],4'b0}, arlen=3, arsize=2, arburst=INCR.
  - Other types: araddr=rd_addr, arlen=0, arsize={1'b0,rd_type[1:0]}, arburst=INCR.
  - R_AR -> R_DATA on arvalid&arready. rready=1 only in R_DATA.
  - ret_valid=rvalid&rready, ret_data=rdata and ret_last=rlast, all combinational pass-through. The cache cannot stall returns.
  - R_DATA -> R_IDLE on the rlast handshake. rresp is ignored.
- Write FSM, states W_IDLE -> W_SEND -> W_RESP -> W_IDLE:
  - wr_rdy = rst & (wstate==W_IDLE).
  - Acceptance latches addr, type, wstrb and the 128-bit data, and clears the beat counter and aw_done.
  - W_SEND: awvalid and wvalid both assert on the cycle after acceptance. Their handshakes are tracked independently: aw_done is set on awready, and awvalid drops.
  - Line write: awaddr={wr_addr[31:4],4'b0}, awlen=3, awsize=2. Beat k carries wdata=data[32k+31:32k] and wstrb=4'hF. wlast=1 when k=3.
  - Single write: awaddr=wr_addr, awlen=0, awsize={1'b0,wr_type[1:0]}, wdata=data[31:0], wstrb=wr_wstrb, wlast=1.
  - The beat counter advances on each wvalid&wready.
  - W_SEND -> W_RESP once aw_done (or the AW handshake in the same cycle) and the wlast handshake have both occurred, in either order or the same cycle.
  - W_RESP: bready=1. Go to W_IDLE on bvalid. bresp is ignored.
- raw_hazard = (wstate!=W_IDLE) & (rd_addr[31:4]==wbuf_addr[31:4]). A read of a line still being written back is held off until the B response returns.
- Simultaneous rd_req and wr_req in one cycle: both are accepted if their conditions hold. A hazard check against a write accepted in the same cycle is not required, because the cache always issues the write-back before the refill.
- AXI stability: all AR/AW/W payload stays constant while the corresponding valid is high and unacknowledged.
- Reset mid-burst: all valids drop immediately and both FSMs return to IDLE. Partial transactions are abandoned; the interconnect is reset together with this block.

Test Plan:
1. Line read, rd_req with rd_type=100 and rd_addr=0x1C00_0024; arready delayed 2 cycles; R beats 0xA0..0xA3 with rlast on the 4th -> araddr=0x1C00_0020, arlen=3, arsize=2; four ret_valid pulses carrying the same data; ret_last on beat 4; rd_rdy back to 1 the next cycle.
2. Word read, rd_type=010, addr 0x8000_0004 -> arlen=0, arsize=2, araddr=0x8000_0004; one ret_valid with ret_last=1.
3. Line write, wr_data=0x4444_4444_3333_3333_2222_2222_1111_1111; awready held 0 for 5 cycles; wready always 1 -> all 4 W beats complete before AW, in the order 0x1111_1111 first, wlast on 0x4444_4444, wstrb=F; bready asserts only after AW completes; wr_rdy=0 until bvalid.
4. Single byte write, wr_type=000, wstrb=4'b0100, addr 0x0000_1002 -> awlen=0, awsize=0, one beat with wstrb=0100 and wlast=1.
5. RAW hazard: line write to 0x2000_0010 pending; rd_req to 0x2000_0018 -> rd_rdy=0 until the cycle after bvalid&bready, then arvalid. A read to 0x2000_0020 during the same window is accepted immediately.
6. Reset asserted during R beat 2 of a line read -> arvalid, rready, ret_valid, rd_rdy and wr_rdy are 0 in the same cycle; after release rd_rdy=wr_rdy=1 and a new read behaves as in test 1.
